// File: rtl/hazard_ctrl.sv
// Pipeline sequencer for the 5-stage MIPS core: load-use stall, branch flush, memory freeze, wait watchdog.
// Optional HAZ_PERF_EN adds saturating stall/flush cycle counters.
module hazard_ctrl #(
   parameter int REG_W    = 5,
   parameter int MAX_WAIT = 15
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             idex_memread_i,
   input  logic [REG_W-1:0] idex_rt_i,
   input  logic [REG_W-1:0] ifid_rs_i,
   input  logic [REG_W-1:0] ifid_rt_i,
   input  logic             ifid_uses_rt_i,
   input  logic             branch_taken_i,
   input  logic             dmem_busy_i,
   output logic             pc_stall_o,
   output logic             ifid_stall_o,
   output logic             idex_bubble_o,
   output logic             flush_o,
   output logic             freeze_o,
   output logic             timeout_o,
   output logic [1:0]       state_o
`ifdef HAZ_PERF_EN
   ,
   output logic [31:0]      stall_cnt_o,
   output logic [15:0]      flush_cnt_o
`endif
);

   typedef enum logic [1:0] {
      RUN      = 2'd0,
      LU_STALL = 2'd1,
      MEMWAIT  = 2'd2,
      FLUSH    = 2'd3
   } state_t;

   localparam logic [7:0] MAX_WAIT_C = 8'(MAX_WAIT);

   function automatic logic [7:0] sat_inc8(input logic [7:0] v);
      return (v == 8'hFF) ? v : v + 8'd1;
   endfunction

   state_t     state, state_nxt;
   logic [7:0] wait_cnt, wait_nxt;
   logic       timeout, timeout_nxt;
   logic       lu;
   logic       stall, flush, freeze;

   assign lu = idex_memread_i && (idex_rt_i != '0) &&
               ((idex_rt_i == ifid_rs_i) || (ifid_uses_rt_i && (idex_rt_i == ifid_rt_i)));

   always_comb begin
      state_nxt   = state;
      wait_nxt    = wait_cnt;
      timeout_nxt = timeout;
      stall       = 1'b0;
      flush       = 1'b0;
      freeze      = 1'b0;
      case (state)
         MEMWAIT: begin
            // branch and load-use are ignored while the pipe is held
            freeze = dmem_busy_i;
            if (dmem_busy_i) begin
               wait_nxt = sat_inc8(wait_cnt);
               if (wait_cnt == MAX_WAIT_C) timeout_nxt = 1'b1;
            end else begin
               wait_nxt  = '0;
               state_nxt = RUN;
            end
         end
         default: begin
            // FLUSH holds a bubble in ID/EX, so taken and lu are not trusted there;
            // LU_STALL masks lu so a load-use costs exactly one bubble
            if (dmem_busy_i) begin
               freeze    = 1'b1;
               wait_nxt  = 8'd1;
               state_nxt = MEMWAIT;
            end else if (branch_taken_i && (state != FLUSH)) begin
               flush     = 1'b1;
               state_nxt = FLUSH;
            end else if (lu && (state == RUN)) begin
               stall     = 1'b1;
               state_nxt = LU_STALL;
            end else begin
               state_nxt = RUN;
            end
         end
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state    <= RUN;
         wait_cnt <= '0;
         timeout  <= 1'b0;
      end else begin
         state    <= state_nxt;
         wait_cnt <= wait_nxt;
         timeout  <= timeout_nxt;
      end
   end

   assign pc_stall_o    = stall  & ~rst_i;
   assign ifid_stall_o  = stall  & ~rst_i;
   assign idex_bubble_o = stall  & ~rst_i;
   assign flush_o       = flush  & ~rst_i;
   assign freeze_o      = freeze & ~rst_i;
   assign timeout_o     = timeout;
   assign state_o       = state;

`ifdef HAZ_PERF_EN
   logic [31:0] stall_cnt;
   logic [15:0] flush_cnt;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         stall_cnt <= '0;
         flush_cnt <= '0;
      end else begin
         if ((pc_stall_o || freeze_o) && (stall_cnt != '1)) stall_cnt <= stall_cnt + 32'd1;
         if (flush_o && (flush_cnt != '1)) flush_cnt <= flush_cnt + 16'd1;
      end
   end

   assign stall_cnt_o = stall_cnt;
   assign flush_cnt_o = flush_cnt;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: directed per-cycle vectors with hand-computed expected outputs.
module tb_hazard_ctrl;

   logic       clk = 1'b0;
   logic       rst_i;
   logic       idex_memread_i;
   logic [4:0] idex_rt_i, ifid_rs_i, ifid_rt_i;
   logic       ifid_uses_rt_i, branch_taken_i, dmem_busy_i;
   logic       pc_stall_o, ifid_stall_o, idex_bubble_o, flush_o, freeze_o, timeout_o;
   logic [1:0] state_o;
`ifdef HAZ_PERF_EN
   logic [31:0] stall_cnt_o;
   logic [15:0] flush_cnt_o;
`endif

   always #5 clk = ~clk;

   hazard_ctrl #(.REG_W(5), .MAX_WAIT(15)) dut (
      .clk_i          (clk),
      .rst_i          (rst_i),
      .idex_memread_i (idex_memread_i),
      .idex_rt_i      (idex_rt_i),
      .ifid_rs_i      (ifid_rs_i),
      .ifid_rt_i      (ifid_rt_i),
      .ifid_uses_rt_i (ifid_uses_rt_i),
      .branch_taken_i (branch_taken_i),
      .dmem_busy_i    (dmem_busy_i),
      .pc_stall_o     (pc_stall_o),
      .ifid_stall_o   (ifid_stall_o),
      .idex_bubble_o  (idex_bubble_o),
      .flush_o        (flush_o),
      .freeze_o       (freeze_o),
      .timeout_o      (timeout_o),
      .state_o        (state_o)
`ifdef HAZ_PERF_EN
      ,
      .stall_cnt_o    (stall_cnt_o),
      .flush_cnt_o    (flush_cnt_o)
`endif
   );

   typedef struct {
      string      name;
      logic [7:0] v;
   } exp_t;

   exp_t q[$];
   int   checks   = 0;
   int   failures = 0;

   // {pc_stall, ifid_stall, idex_bubble, flush, freeze, timeout, state}
   function automatic logic [7:0] mk(input logic ps, is, bb, fl, fr, to, input logic [1:0] st);
      return {ps, is, bb, fl, fr, to, st};
   endfunction

   task automatic cyc(input string n, input logic r, mr, input logic [4:0] irt, rs, rt,
                      input logic u, tk, bz, input logic chk, input logic [7:0] e);
      exp_t x;
      @(posedge clk);
      #1;
      rst_i          = r;
      idex_memread_i = mr;
      idex_rt_i      = irt;
      ifid_rs_i      = rs;
      ifid_rt_i      = rt;
      ifid_uses_rt_i = u;
      branch_taken_i = tk;
      dmem_busy_i    = bz;
      if (chk) begin
         x.name = n;
         x.v    = e;
         q.push_back(x);
      end
   endtask

   // monitor: outputs are Mealy, so every cycle presents a result
   initial begin
      exp_t       e;
      logic [7:0] act;
      forever begin
         @(negedge clk);
         if (q.size() > 0) begin
            e   = q.pop_front();
            act = {pc_stall_o, ifid_stall_o, idex_bubble_o, flush_o, freeze_o, timeout_o, state_o};
            checks++;
            if (act !== e.v) begin
               failures++;
               $display("FAIL %s actual=%b required=%b (ps,is,bb,fl,fr,to,st)", e.name, act, e.v);
            end
         end
      end
   end

   initial begin
      rst_i = 1'b1; idex_memread_i = 1'b0; idex_rt_i = '0; ifid_rs_i = '0; ifid_rt_i = '0;
      ifid_uses_rt_i = 1'b0; branch_taken_i = 1'b0; dmem_busy_i = 1'b0;
      repeat (2) @(posedge clk);

      cyc("rst_lu",   1, 1, 8, 8, 0, 0, 0, 0, 1, mk(0,0,0,0,0,0,2'd0));
      cyc("rst_busy", 1, 0, 0, 0, 0, 0, 0, 1, 1, mk(0,0,0,0,0,0,2'd0));
      cyc("lu_rs",    0, 1, 8, 8, 0, 0, 0, 0, 1, mk(1,1,1,0,0,0,2'd0));
      cyc("lu_mask",  0, 1, 8, 8, 0, 0, 0, 0, 1, mk(0,0,0,0,0,0,2'd1));
      cyc("rt_zero",  0, 1, 0, 0, 0, 0, 0, 0, 1, mk(0,0,0,0,0,0,2'd0));
      cyc("no_uses",  0, 1, 8, 3, 8, 0, 0, 0, 1, mk(0,0,0,0,0,0,2'd0));
      cyc("uses_rt",  0, 1, 8, 3, 8, 1, 0, 0, 1, mk(1,1,1,0,0,0,2'd0));
      cyc("lus_take", 0, 0, 0, 0, 0, 0, 1, 0, 1, mk(0,0,0,1,0,0,2'd1));
      cyc("fl_mask",  0, 1, 8, 8, 0, 0, 1, 0, 1, mk(0,0,0,0,0,0,2'd3));
      cyc("take_lu",  0, 1, 8, 8, 0, 0, 1, 0, 1, mk(0,0,0,1,0,0,2'd0));
      cyc("fl_lu",    0, 1, 8, 8, 0, 0, 0, 0, 1, mk(0,0,0,0,0,0,2'd3));

      cyc("busy0",    0, 1, 8, 8, 0, 0, 0, 1, 1, mk(0,0,0,0,1,0,2'd0));
      cyc("busy1",    0, 0, 0, 0, 0, 0, 0, 1, 1, mk(0,0,0,0,1,0,2'd2));
      cyc("busy2_tk", 0, 0, 0, 0, 0, 0, 1, 1, 1, mk(0,0,0,0,1,0,2'd2));
      cyc("busy3",    0, 1, 8, 8, 0, 0, 0, 1, 1, mk(0,0,0,0,1,0,2'd2));
      cyc("busy_end", 0, 1, 8, 8, 0, 0, 1, 0, 1, mk(0,0,0,0,0,0,2'd2));
      cyc("post_lu",  0, 1, 8, 8, 0, 0, 0, 0, 1, mk(1,1,1,0,0,0,2'd0));
      cyc("lus_busy", 0, 0, 0, 0, 0, 0, 1, 1, 1, mk(0,0,0,0,1,0,2'd1));
      cyc("lus_bend", 0, 0, 0, 0, 0, 0, 0, 0, 1, mk(0,0,0,0,0,0,2'd2));

      for (int k = 0; k < 20; k++)
         cyc($sformatf("to_%0d", k), 0, 0, 0, 0, 0, 0, 0, 1, 1,
             mk(0,0,0,0,1, logic'(k >= 16), (k == 0) ? 2'd0 : 2'd2));
      cyc("to_rel",    0, 0, 0, 0, 0, 0, 0, 0, 1, mk(0,0,0,0,0,1,2'd2));
      cyc("to_sticky", 0, 1, 8, 8, 0, 0, 0, 0, 1, mk(1,1,1,0,0,1,2'd0));
      cyc("to_lus",    0, 0, 0, 0, 0, 0, 0, 0, 1, mk(0,0,0,0,0,1,2'd1));

      cyc("mw_enter",  0, 0, 0, 0, 0, 0, 0, 1, 1, mk(0,0,0,0,1,1,2'd0));
      cyc("mw_busy",   0, 0, 0, 0, 0, 0, 0, 1, 1, mk(0,0,0,0,1,1,2'd2));
      cyc("mw_rst",    1, 0, 0, 0, 0, 0, 0, 1, 0, 8'd0);
      cyc("after_rst", 0, 0, 0, 0, 0, 0, 0, 0, 1, mk(0,0,0,0,0,0,2'd0));
`ifdef HAZ_PERF_EN
      @(negedge clk);
      checks++;
      if ((stall_cnt_o !== 32'd0) || (flush_cnt_o !== 16'd0)) begin
         failures++;
         $display("FAIL perf_cnt_rst actual=%0d/%0d required=0/0", stall_cnt_o, flush_cnt_o);
      end
`endif
      cyc("rst_bsy2",  0, 0, 0, 0, 0, 0, 0, 1, 1, mk(0,0,0,0,1,0,2'd0));
      cyc("rst_bsy3",  0, 0, 0, 0, 0, 0, 0, 0, 1, mk(0,0,0,0,0,0,2'd2));
      cyc("idle",      0, 0, 0, 0, 0, 0, 0, 0, 1, mk(0,0,0,0,0,0,2'd0));

      for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge clk);
      @(posedge clk);
      if (q.size() > 0) begin
         failures++;
         $display("FAIL drain actual=%0d pending required=0", q.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
